cskipa_mc_wrapper: RTL and testbench

- Sequential issue/capture stage for the 12-bit carry-skip adder netlist.
- Accepts operand pairs over valid/ready and buffers them in a small FIFO.
- Drives the adder's operand inputs from stable registers for a programmable multicycle settle window, then captures sum/cout and presents them on a valid/ready result port.
- Sits directly upstream (operand drive) and downstream (result capture) of the combinational adder.

---
 rtl/cskipa_mc_wrapper.sv | 146 ++++++++++++++
 tb/tb_cskipa_mc_wrapper.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cskipa_mc_wrapper.sv
// rtl/cskipa_mc_wrapper.sv - multicycle issue/capture stage around the 12-bit carry-skip adder
// Optional self-check of captured results against launched operands: define ADD_SELFCHECK_EN.
module cskipa_mc_wrapper #(
  parameter int WIDTH      = 12,
  parameter int SETTLE_CYC = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_cout,
  output logic             o_busy
`ifdef ADD_SELFCHECK_EN
  ,
  output logic             o_mismatch,
  output logic [7:0]       o_err_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE_CYC);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [WIDTH-1:0] r_fifo_a [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fifo_b [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_state;
  logic [3:0]       r_cnt;

  logic w_push;
  logic w_pop;
  logic w_nonempty;
  logic w_capture;

  assign w_nonempty = (r_count != '0);
  assign o_in_ready = (r_count != DEPTH_C);
  assign w_push     = i_in_valid && o_in_ready;
  // Pop only when the operand registers are free: from IDLE, or on the result handshake in HOLD.
  assign w_pop      = w_nonempty &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && i_out_ready));
  assign w_capture  = (r_state == S_SETTLE) && (r_cnt == 4'd1);
  assign o_busy     = (r_state != S_IDLE) || w_nonempty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= i_in_a;
      r_fifo_b[r_wr_ptr] <= i_in_b;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      o_add_term1 <= '0;
      o_add_term2 <= '0;
      o_out_sum   <= '0;
      o_out_cout  <= 1'b0;
      o_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            o_add_term1 <= r_fifo_a[r_rd_ptr];
            o_add_term2 <= r_fifo_b[r_rd_ptr];
            r_cnt       <= SETTLE_C;
            r_state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_capture) begin
            o_out_sum   <= i_sum;
            o_out_cout  <= i_cout;
            o_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            // Back-to-back: relaunch on the same edge the result is consumed.
            if (w_pop) begin
              o_add_term1 <= r_fifo_a[r_rd_ptr];
              o_add_term2 <= r_fifo_b[r_rd_ptr];
              r_cnt       <= SETTLE_C;
              r_state     <= S_SETTLE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ADD_SELFCHECK_EN
  logic [WIDTH:0] w_expect;
  assign w_expect = {1'b0, o_add_term1} + {1'b0, o_add_term2};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mismatch <= 1'b0;
      o_err_cnt  <= '0;
    end else if (w_capture && ({i_cout, i_sum} != w_expect)) begin
      o_mismatch <= 1'b1;
      if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cskipa_mc_wrapper.sv
// tb/tb_cskipa_mc_wrapper.sv - table, sequence and randomized scoreboard bench for cskipa_mc_wrapper
module tb_cskipa_mc_wrapper;

  localparam int W = 12;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [W-1:0] i_in_a;
  logic [W-1:0] i_in_b;
  logic [W-1:0] o_add_term1;
  logic [W-1:0] o_add_term2;
  logic [W-1:0] i_sum;
  logic         i_cout;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [W-1:0] o_out_sum;
  logic         o_out_cout;
  logic         o_busy;
  logic         corrupt = 1'b0;
  logic         sb_en = 1'b1;
`ifdef ADD_SELFCHECK_EN
  logic         o_mismatch;
  logic [7:0]   o_err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  // Combinational adder stand-in; corrupt flips the sum LSB.
  logic [W:0] add_res;
  assign add_res = {1'b0, o_add_term1} + {1'b0, o_add_term2};
  assign i_sum   = add_res[W-1:0] ^ {{(W-1){1'b0}}, corrupt};
  assign i_cout  = add_res[W];

  cskipa_mc_wrapper #(.WIDTH(W), .SETTLE_CYC(2), .FIFO_DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_add_term1(o_add_term1), .o_add_term2(o_add_term2),
    .i_sum(i_sum), .i_cout(i_cout),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_sum(o_out_sum), .o_out_cout(o_out_cout),
    .o_busy(o_busy)
`ifdef ADD_SELFCHECK_EN
    , .o_mismatch(o_mismatch), .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected results are A+B taken at acceptance, consumed in order.
  logic [W:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [W:0] prev_res;
  logic [W-1:0] prev_t1, prev_t2;

  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else if (sb_en) begin
      if (prev_stall) begin
        chk("hold_result_stable", 32'({o_out_cout, o_out_sum}), 32'(prev_res));
        chk("hold_term1_stable", 32'(o_add_term1), 32'(prev_t1));
        chk("hold_term2_stable", 32'(o_add_term2), 32'(prev_t2));
      end
      if (i_in_valid && o_in_ready)
        exp_q.push_back((W+1)'(i_in_a) + (W+1)'(i_in_b));
      if (o_out_valid && i_out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("sb_spurious_result", 32'd1, 32'd0);
        else chk("sb_result", 32'({o_out_cout, o_out_sum}), 32'(exp_q.pop_front()));
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_res   = {o_out_cout, o_out_sum};
      prev_t1    = o_add_term1;
      prev_t2    = o_add_term2;
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc = 1'b0;
    i_in_valid = 1'b1; i_in_a = a; i_in_b = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge i_clk); acc = o_in_ready;
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string name, input int bound);
    logic done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge i_clk);
      done = (exp_q.size() == 0) && !o_busy;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{12'h123, 12'h456, 12'h579, 1'b0};
    tbl[1] = '{12'hFFF, 12'h001, 12'h000, 1'b1};
    tbl[2] = '{12'h800, 12'h800, 12'h000, 1'b1};
    tbl[3] = '{12'h000, 12'h000, 12'h000, 1'b0};
    tbl[4] = '{12'hFFF, 12'hFFF, 12'hFFE, 1'b1};
    tbl[5] = '{12'h7FF, 12'h001, 12'h800, 1'b0};

    i_rst = 1'b1; i_in_valid = 1'b0; i_in_a = '0; i_in_b = '0; i_out_ready = 1'b0;
    #2;
    chk("rst_term1", 32'(o_add_term1), 32'd0);
    chk("rst_term2", 32'(o_add_term2), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_sum", 32'({o_out_cout, o_out_sum}), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);

    // Single ops: launch one edge after push, capture two edges after launch.
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      i_in_valid = 1'b1; i_in_a = tbl[i].a; i_in_b = tbl[i].b;
      @(posedge i_clk); #1;
      i_in_valid = 1'b0;
      @(posedge i_clk); #1;
      chk("op_launch_term1", 32'(o_add_term1), 32'(tbl[i].a));
      chk("op_launch_term2", 32'(o_add_term2), 32'(tbl[i].b));
      chk("op_valid_at_L", 32'(o_out_valid), 32'd0);
      @(posedge i_clk); #1;
      chk("op_valid_at_L1", 32'(o_out_valid), 32'd0);
      @(posedge i_clk); #1;
      chk("op_valid_at_L2", 32'(o_out_valid), 32'd1);
      chk("op_sum", 32'(o_out_sum), 32'(tbl[i].sum));
      chk("op_cout", 32'(o_out_cout), 32'(tbl[i].cout));
      i_out_ready = 1'b1;
      @(posedge i_clk); #1;
      i_out_ready = 1'b0;
      chk("op_valid_after_hs", 32'(o_out_valid), 32'd0);
      chk("op_idle_after_hs", 32'(o_busy), 32'd0);
    end

    // Backpressure: one in flight plus two buffered, fourth pair must stall.
    begin
      int base;
      logic acc = 1'b0;
      base = n_out;
      push(12'h0AB, 12'h0CD);
      push(12'h111, 12'h222);
      push(12'hF00, 12'h200);
      chk("bp_full_ready_low", 32'(o_in_ready), 32'd0);
      i_in_valid = 1'b1; i_in_a = 12'h345; i_in_b = 12'hCBB;
      repeat (6) @(negedge i_clk);
      chk("bp_still_full", 32'(o_in_ready), 32'd0);
      chk("bp_valid_held", 32'(o_out_valid), 32'd1);
      chk("bp_held_result", 32'({o_out_cout, o_out_sum}), 32'h178);
      chk("bp_held_term1", 32'(o_add_term1), 32'h0AB);
      chk("bp_held_term2", 32'(o_add_term2), 32'h0CD);
      @(posedge i_clk); #1;
      i_out_ready = 1'b1;
      for (int k = 0; k < 30 && !acc; k++) begin
        @(negedge i_clk); acc = o_in_ready;
        @(posedge i_clk); #1;
      end
      i_in_valid = 1'b0;
      chk("bp_fourth_accepted", 32'(acc), 32'd1);
      drain("bp_drain", 60);
      chk("bp_result_count", 32'(n_out - base), 32'd4);
    end

    // Back-to-back with ready high: one result every SETTLE_CYC+1 edges.
    begin
      int t_last = -1;
      int pulses = 0;
      i_out_ready = 1'b1;
      i_in_valid  = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge i_clk);
        if (o_out_valid) begin
          if (t_last >= 0) chk("b2b_gap", 32'(c - t_last), 32'd3);
          t_last = c;
          pulses++;
        end
        @(posedge i_clk); #1;
        i_in_a = W'(c * 37); i_in_b = W'(12'hF80 + c);
      end
      i_in_valid = 1'b0;
      chk("b2b_pulse_count", 32'(pulses >= 12), 32'd1);
      drain("b2b_drain", 60);
    end

    // Reset one edge after launch: outputs clear at once, no stale result later.
    i_out_ready = 1'b0;
    @(posedge i_clk); #1;
    i_in_valid = 1'b1; i_in_a = 12'h5A5; i_in_b = 12'h0F0;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("mid_launch_term1", 32'(o_add_term1), 32'h5A5);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_term1", 32'(o_add_term1), 32'd0);
    chk("mid_rst_term2", 32'(o_add_term2), 32'd0);
    chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("post_rst_no_stale", 32'(o_out_valid), 32'd0);
    end
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_in_ready", 32'(o_in_ready), 32'd1);

`ifdef ADD_SELFCHECK_EN
    sb_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      corrupt = (k == 0);
      @(posedge i_clk); #1;
      i_in_valid = 1'b1; i_in_a = W'(12'h321 + k); i_in_b = 12'h0FE;
      @(posedge i_clk); #1;
      i_in_valid = 1'b0;
      repeat (3) @(posedge i_clk); #1;
      i_out_ready = 1'b1;
      @(posedge i_clk); #1;
      i_out_ready = 1'b0;
      corrupt = 1'b0;
      chk("selfcheck_mismatch", 32'(o_mismatch), 32'd1);
      chk("selfcheck_err_cnt", 32'(o_err_cnt), 32'd1);
    end
    sb_en = 1'b1;
`endif

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      @(posedge i_clk); #1;
      i_in_valid  = 1'($urandom_range(0, 1));
      i_in_a      = W'($urandom);
      i_in_b      = W'($urandom);
      i_out_ready = ($urandom_range(0, 3) != 0);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    drain("rand_drain", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
